data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 25 ++
 rtl/data_mem_resp_byte_lane.sv | 21 ++
 rtl/data_mem_resp.sv | 118 +++++++++++
 tb/tb_data_mem_resp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared types for the data memory response block.
// Holds the core<->memory bundles and the response FSM states.
package data_mem_resp_pkg;

   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/data_mem_resp_byte_lane.sv
// Byte-lane select and merge for one 32-bit word.
// Ports: word_i (array word), lane_i (byte lane), byte_i (store byte),
//        byte_o (selected byte), merged_o (word with lane replaced).
module dmem_byte_lane (
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [7:0]  byte_i,
   output logic [7:0]  byte_o,
   output logic [31:0] merged_o
);

   logic [4:0] lsb;
   assign lsb = {lane_i, 3'b000};

   always_comb begin
      byte_o             = word_i[lsb +: 8];
      merged_o           = word_i;
      merged_o[lsb +: 8] = byte_i;
   end

endmodule

// File: rtl/data_mem_resp.sv
// Word-array data memory with fixed-latency valid/yumi responses.
// Ports: clk, reset (sync, active-low), to_mem_i (core request),
//        addr_i (byte address), from_mem_o (response + accept).
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int unsigned addr_width_p = 10,
   parameter int unsigned latency_p    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  mem_in_s     to_mem_i,
   input  logic [31:0] addr_i,
   output mem_out_s    from_mem_o
);

   localparam int unsigned Depth    = 1 << addr_width_p;
   localparam int unsigned BusyLast = (latency_p > 1) ? latency_p - 2 : 0;

   dmem_state_e state_q;
   logic        valid_q;
   logic [31:0] rdata_q;
   logic [31:0] pend_q;
   logic [2:0]  cnt_q;

   logic [31:0] mem_q [Depth];

   logic [addr_width_p-1:0] idx;
   logic [1:0]              lane;
   logic                    accept;
   logic [31:0]             rd_word;
   logic [7:0]              rd_byte;
   logic [31:0]             merged;
   logic [31:0]             st_word;
   logic [31:0]             ld_val;

   // Upper address bits only alias; they carry no information here.
   logic unused_addr;
   assign unused_addr = ^addr_i[31:2+addr_width_p];

   assign idx     = addr_i[2 +: addr_width_p];
   assign lane    = addr_i[1:0];
   assign accept  = to_mem_i.valid & (state_q == IDLE) & reset;
   assign rd_word = mem_q[idx];

   dmem_byte_lane u_lane (
      .word_i   (rd_word),
      .lane_i   (lane),
      .byte_i   (to_mem_i.write_data[7:0]),
      .byte_o   (rd_byte),
      .merged_o (merged)
   );

   assign st_word = to_mem_i.byte_not_word ? merged
                                           : to_mem_i.write_data;

   // Load data is taken from the pre-edge array; stores report zero.
   always_comb begin
      ld_val = rd_word;
      if (to_mem_i.wen)
         ld_val = '0;
      else if (to_mem_i.byte_not_word)
         ld_val = {24'b0, rd_byte};
   end

   // Array is never reset; a store commits on its accept edge.
   always_ff @(posedge clk) begin
      if (accept && to_mem_i.wen)
         mem_q[idx] <= st_word;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         rdata_q <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  pend_q <= ld_val;
                  cnt_q  <= '0;
                  if (latency_p == 1) begin
                     state_q <= RESP;
                     valid_q <= 1'b1;
                     rdata_q <= ld_val;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt_q == 3'(BusyLast)) begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  rdata_q <= pend_q;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            RESP: begin
               if (to_mem_i.yumi) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign from_mem_o = '{read_data: rdata_q,
                         valid:     valid_q,
                         yumi:      accept};

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (latency_p=2, 1K words).
// Table of single transactions plus hand-written multi-cycle sequences.
module tb_data_mem_resp;
   import data_mem_resp_pkg::*;

   logic        clk;
   logic        reset;
   mem_in_s     to_mem;
   logic [31:0] addr;
   mem_out_s    from_mem;

   int checks   = 0;
   int failures = 0;

   data_mem_resp #(.addr_width_p(10), .latency_p(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .to_mem_i   (to_mem),
      .addr_i     (addr),
      .from_mem_o (from_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        wen;
      logic        bnw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      to_mem.valid         = 1'b0;
      to_mem.wen           = 1'b0;
      to_mem.byte_not_word = 1'b0;
      to_mem.write_data    = '0;
   endtask

   // Wait for valid (bounded), check data, then handshake.
   task automatic drain(input string name, input logic [31:0] exp,
                        input int exp_lat);
      int n;
      n = 1;
      while (!from_mem.valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_lat"}, 32'(n), 32'(exp_lat));
      chk({name, "_data"}, from_mem.read_data, exp);
      to_mem.yumi = 1'b1;
      @(posedge clk);
      @(negedge clk);
      to_mem.yumi = 1'b0;
      #1;
      chk({name, "_vdrop"}, 32'(from_mem.valid), 32'd0);
   endtask

   task automatic txn(input string name, input logic wen, input logic bnw,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp);
      @(negedge clk);
      to_mem.valid         = 1'b1;
      to_mem.wen           = wen;
      to_mem.byte_not_word = bnw;
      to_mem.write_data    = wd;
      addr                 = a;
      #1;
      chk({name, "_acc"}, 32'(from_mem.yumi), 32'd1);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      drain(name, exp, 2);
   endtask

   initial begin
      logic [31:0] held;

      vecs[0]  = '{"st_word",   1, 0, 32'h10,   32'hDEADBEEF, 32'h0};
      vecs[1]  = '{"ld_word",   0, 0, 32'h10,   32'h0,        32'hDEADBEEF};
      vecs[2]  = '{"st_base",   1, 0, 32'h10,   32'h11223344, 32'h0};
      vecs[3]  = '{"st_byte",   1, 1, 32'h13,   32'h000000AB, 32'h0};
      vecs[4]  = '{"ld_merged", 0, 0, 32'h10,   32'h0,        32'hAB223344};
      vecs[5]  = '{"ld_b3",     0, 1, 32'h13,   32'h0,        32'h000000AB};
      vecs[6]  = '{"ld_b0",     0, 1, 32'h10,   32'h0,        32'h00000044};
      vecs[7]  = '{"ld_b1",     0, 1, 32'h11,   32'h0,        32'h00000033};
      vecs[8]  = '{"ld_misal",  0, 0, 32'h12,   32'h0,        32'hAB223344};
      vecs[9]  = '{"st_alias",  1, 0, 32'h1000, 32'h5,        32'h0};
      vecs[10] = '{"ld_alias",  0, 0, 32'h0,    32'h0,        32'h5};
      vecs[11] = '{"st_zero",   1, 0, 32'h20,   32'h0,        32'h0};
      vecs[12] = '{"st_b1hi",   1, 1, 32'h21,   32'hFFFFFF5A, 32'h0};

      reset       = 1'b0;
      addr        = '0;
      to_mem.yumi = 1'b0;
      idle_inputs();
      to_mem.valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_yumi", 32'(from_mem.yumi), 32'd0);
      chk("rst_valid", 32'(from_mem.valid), 32'd0);
      chk("rst_rdata", from_mem.read_data, 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      idle_inputs();
      reset = 1'b1;

      foreach (vecs[i])
         txn(vecs[i].name, vecs[i].wen, vecs[i].bnw, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp);
      txn("ld_b1word", 0, 0, 32'h20, 32'h0, 32'h00005A00);

      // Backpressure: hold off yumi for five cycles.
      @(negedge clk);
      to_mem.valid = 1'b1;
      addr         = 32'h10;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      while (!from_mem.valid && checks < 100000) @(negedge clk);
      held = from_mem.read_data;
      chk("bp_data", held, 32'hAB223344);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(from_mem.valid), 32'd1);
         chk("bp_hold", from_mem.read_data, 32'hAB223344);
         chk("bp_state", 32'(dut.state_q), 32'(RESP));
         @(negedge clk);
      end
      to_mem.yumi = 1'b1;
      @(posedge clk);
      @(negedge clk);
      to_mem.yumi = 1'b0;
      #1;
      chk("bp_vdrop", 32'(from_mem.valid), 32'd0);
      chk("bp_keep", from_mem.read_data, 32'hAB223344);

      // Busy rejection with valid held high, stray yumi in BUSY.
      @(negedge clk);
      to_mem.valid = 1'b1;
      addr         = 32'h0;
      #1;
      chk("busy_acc", 32'(from_mem.yumi), 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("busy_rej", 32'(from_mem.yumi), 32'd0);
      to_mem.yumi = 1'b1;
      @(negedge clk);
      to_mem.yumi = 1'b0;
      #1;
      chk("busy_valid", 32'(from_mem.valid), 32'd1);
      chk("busy_data", from_mem.read_data, 32'h5);
      chk("resp_rej", 32'(from_mem.yumi), 32'd0);
      @(negedge clk);
      chk("resp_stay", 32'(from_mem.valid), 32'd1);
      to_mem.yumi = 1'b1;
      #1;
      chk("hs_rej", 32'(from_mem.yumi), 32'd0);
      @(posedge clk);
      @(negedge clk);
      to_mem.yumi = 1'b0;
      #1;
      chk("reacc", 32'(from_mem.yumi), 32'd1);
      chk("reacc_v", 32'(from_mem.valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      drain("reacc_ld", 32'h5, 2);

      // Reset while BUSY after a store.
      @(negedge clk);
      to_mem.valid      = 1'b1;
      to_mem.wen        = 1'b1;
      to_mem.write_data = 32'h7;
      addr              = 32'h20;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk("mid_busy", 32'(dut.state_q), 32'(BUSY));
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("mid_valid", 32'(from_mem.valid), 32'd0);
      chk("mid_state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_quiet", 32'(from_mem.valid), 32'd0);
      txn("mid_ld", 0, 0, 32'h20, 32'h0, 32'h7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=done");
      $fatal(1, "timeout");
   end

endmodule
